// File: rtl/pixel_stream_source.sv
// pixel_stream_source: raster-order frame reader with valid/stall output and a one-entry skid register
// Ports: clk; rst (async, active-low); start (frame request, IDLE only);
//   busy/done (frame status); mem_rd_en/mem_addr/mem_rd_data (sync-read RAM, 1-cycle latency);
//   stall (downstream backpressure); data_out/valid_out/plane_last/chan_idx (pixel stream).
module pixel_stream_source #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 5,
  parameter int HEIGHT     = 5,
  parameter int CHANNELS   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  plane_last,
  output logic [7:0]            chan_idx
);
  localparam int PLANE = WIDTH * HEIGHT;
  localparam int TOTAL = PLANE * CHANNELS;
  localparam int PW    = $clog2(PLANE) > 0 ? $clog2(PLANE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [PW-1:0]         pix;
  logic [7:0]            ch;
  logic                  fl_v, fl_last;
  logic [7:0]            fl_ch;
  logic                  sk_v, sk_last;
  logic [7:0]            sk_ch;
  logic [DATA_WIDTH-1:0] sk_data;
  logic                  issue, free, pix_end;
  // A read is only issued when its return is guaranteed a home: the skid is empty
  // and the output is not stalled, so the skid can never overflow.
  assign issue     = state == RUN && !stall && !sk_v;
  assign free      = !valid_out || !stall;
  assign pix_end   = pix == PW'(PLANE - 1);
  assign mem_rd_en = issue;
  assign mem_addr  = state == IDLE ? '0 : ADDR_WIDTH'(BASE_ADDR) + idx;
  assign busy      = state == RUN || state == DRAIN;
  assign done      = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      pix        <= '0;
      ch         <= '0;
      fl_v       <= 1'b0;
      fl_last    <= 1'b0;
      fl_ch      <= '0;
      sk_v       <= 1'b0;
      sk_last    <= 1'b0;
      sk_ch      <= '0;
      sk_data    <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      plane_last <= 1'b0;
      chan_idx   <= '0;
    end else begin
      fl_v    <= issue;
      fl_last <= pix_end;
      fl_ch   <= ch;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          idx   <= '0;
          pix   <= '0;
          ch    <= '0;
        end
        RUN: if (issue) begin
          idx   <= idx + 1'b1;
          pix   <= pix_end ? '0 : pix + 1'b1;
          ch    <= ch + 8'(pix_end);
          state <= idx == ADDR_WIDTH'(TOTAL - 1) ? DRAIN : RUN;
        end
        // Last pixel leaves only when nothing remains in flight or in the skid.
        DRAIN: if (valid_out && !stall && !sk_v && !fl_v) state <= DONE;
        DONE: state <= IDLE;
      endcase
      if (free) begin
        valid_out <= sk_v || fl_v;
        sk_v      <= 1'b0;
        if (sk_v) begin
          data_out   <= sk_data;
          plane_last <= sk_last;
          chan_idx   <= sk_ch;
        end else if (fl_v) begin
          data_out   <= mem_rd_data;
          plane_last <= fl_last;
          chan_idx   <= fl_ch;
        end
      end else if (fl_v) begin
        sk_v    <= 1'b1;
        sk_data <= mem_rd_data;
        sk_last <= fl_last;
        sk_ch   <= fl_ch;
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_source.sv
// tb_pixel_stream_source: directed vectors and stream scoreboard for pixel_stream_source
module tb_pixel_stream_source;
  logic        clk = 0, rst = 0, start = 0, stall = 0;
  logic        busy, done, mem_rd_en, valid_out, plane_last;
  logic [15:0] mem_addr;
  logic [31:0] mem_rd_data = '0, data_out;
  logic [7:0]  chan_idx;
  int          compared = 0, mismatched = 0;
  int          nxt, bubbles;
  bit          pstall_v, prev49;
  logic [31:0] pd;
  logic        pl;
  logic [7:0]  pc;
  typedef struct {int cyc; bit rd; int addr; bit v; int d; bit last; int ch; bit busy; bit done;} vec_t;
  vec_t tbl[10];
  pixel_stream_source #(.DATA_WIDTH(32), .WIDTH(5), .HEIGHT(5), .CHANNELS(2),
    .ADDR_WIDTH(16), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .stall(stall), .data_out(data_out), .valid_out(valid_out),
    .plane_last(plane_last), .chan_idx(chan_idx));
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= 32'(mem_addr);
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_last"}, plane_last, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_chan"}, chan_idx, 0);
  endtask
  // mode: 0 plain, 1 random stall, 2 stall on pixel 7, 3 stall on pixel 49,
  // 4 start re-pulsed in RUN/DONE, 5 reset while pixel 17 presented
  task automatic run_frame(input int mode);
    int cyc = 0;
    bit fin = 0, this49;
    int exp_done = (mode == 0 || mode == 4) ? 53 : mode == 2 ? 64 : mode == 3 ? 58 : -1;
    nxt = 0; bubbles = 0; pstall_v = 0; prev49 = 0;
    while (!fin && cyc < 300) begin
      start = (cyc == 0) || (mode == 4 && (cyc == 20 || cyc == 53));
      stall = mode == 1 ? ($urandom_range(0, 99) < 30) : mode == 2 ? (cyc >= 10 && cyc <= 19) :
              mode == 3 ? (cyc >= 52 && cyc <= 56) : 1'b0;
      #1;
      this49 = 0;
      if (mode == 0 || mode == 4)
        foreach (tbl[i]) if (tbl[i].cyc == cyc) begin
          chk("tbl_rd_en", mem_rd_en, tbl[i].rd);
          if (tbl[i].rd) chk("tbl_addr", mem_addr, tbl[i].addr);
          chk("tbl_valid", valid_out, tbl[i].v);
          if (tbl[i].v) begin
            chk("tbl_data", data_out, tbl[i].d);
            chk("tbl_last", plane_last, tbl[i].last);
            chk("tbl_chan", chan_idx, tbl[i].ch);
          end
          chk("tbl_busy", busy, tbl[i].busy);
          chk("tbl_done", done, tbl[i].done);
        end
      if (pstall_v) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_data", data_out, pd);
        chk("hold_last", plane_last, pl);
        chk("hold_chan", chan_idx, pc);
      end
      if (valid_out && !stall) begin
        chk("xfer_data", data_out, nxt);
        chk("xfer_last", plane_last, nxt % 25 == 24);
        chk("xfer_chan", chan_idx, nxt / 25);
        this49 = nxt == 49;
        nxt++;
      end
      if (cyc >= 3 && busy && !valid_out) bubbles++;
      if (mode == 2 && cyc >= 11 && cyc <= 19) chk("stall_rd_en", mem_rd_en, 0);
      if (mode == 3 && cyc >= 52 && cyc <= 56) begin
        chk("drain_busy", busy, 1);
        chk("drain_done", done, 0);
      end
      if (done) begin
        if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
        chk("done_count", nxt, 50);
        chk("done_after_49", prev49, 1);
        fin = 1;
      end
      if (mode == 5 && cyc == 20) begin
        chk("pre_reset_data", data_out, 17);
        #1 rst = 0;
        #1 chk_zero("async_reset");
        fin = 1;
      end
      pstall_v = valid_out && stall;
      pd = data_out; pl = plane_last; pc = chan_idx;
      prev49 = this49;
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin) begin
      compared++; mismatched++;
      $display("FAIL frame_timeout: mode %0d got no done within %0d cycles", mode, cyc);
    end
    start = 0; stall = 0;
    if (mode != 1 && mode != 5) chk("bubbles", bubbles, mode == 2 ? 1 : 0);
  endtask
  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 0, 0, 1, 0};
    tbl[2] = '{2, 1, 1, 0, 0, 0, 0, 1, 0};
    tbl[3] = '{3, 1, 2, 1, 0, 0, 0, 1, 0};
    tbl[4] = '{27, 1, 26, 1, 24, 1, 0, 1, 0};
    tbl[5] = '{28, 1, 27, 1, 25, 0, 1, 1, 0};
    tbl[6] = '{50, 1, 49, 1, 47, 0, 1, 1, 0};
    tbl[7] = '{51, 0, 0, 1, 48, 0, 1, 1, 0};
    tbl[8] = '{52, 0, 0, 1, 49, 1, 1, 1, 0};
    tbl[9] = '{53, 0, 0, 0, 0, 0, 0, 0, 1};
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    #2 rst = 1;
    @(posedge clk); #1;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(4);
    repeat (5) begin
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid_out, 0);
      chk("idle_rd_en", mem_rd_en, 0);
      @(posedge clk); #1;
    end
    run_frame(0);
    run_frame(3);
    run_frame(5);
    @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #1;
    run_frame(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
